// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC infrared transmitter: FSM states, per-state
// unit counts and frame geometry.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GUARD
  } nec_state_e;

  localparam int LEAD_MARK_UNITS  = 16;
  localparam int LEAD_SPACE_UNITS = 8;
  localparam int REP_SPACE_UNITS  = 4;
  localparam int BIT_MARK_UNITS   = 1;
  localparam int ZERO_SPACE_UNITS = 1;
  localparam int ONE_SPACE_UNITS  = 3;
  localparam int STOP_MARK_UNITS  = 1;
  localparam int FRAME_BITS       = 32;

  function automatic logic is_mark(input nec_state_e s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/nec_ir_carrier.sv
// Carrier square wave: toggles every CAR_HALF cycles while enabled; a restart
// forces the phase high so every mark begins with the carrier on.
module nec_ir_carrier #(
  parameter int CAR_HALF = 658
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic restart,
  output logic carrier
);

  localparam int HW = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;

  logic [HW-1:0] cnt_q, cnt_d;
  logic          car_q, car_d;

  always_comb begin
    cnt_d = cnt_q;
    car_d = car_q;
    if (restart) begin
      cnt_d = '0;
      car_d = 1'b1;
    end else if (!en) begin
      cnt_d = '0;
      car_d = 1'b0;
    end else if (cnt_q == HW'(CAR_HALF - 1)) begin
      cnt_d = '0;
      car_d = ~car_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      car_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      car_q <= car_d;
    end
  end

  assign carrier = car_q;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC infrared frame / repeat-code transmitter with carrier-modulated LED drive
// and an enforced idle guard after every transmission.
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYC    = 28125,
  parameter int CAR_HALF    = 658,
  parameter int GUARD_UNITS = 72
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_start,
  input  logic       tx_repeat,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ir_env,
  output logic       ir_out
);

  localparam int CW   = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int MAXU = (GUARD_UNITS > LEAD_MARK_UNITS) ? GUARD_UNITS : LEAD_MARK_UNITS;
  localparam int UW   = $clog2(MAXU + 1);

  nec_state_e                  state_q, state_d;
  logic [CW-1:0]               cyc_q, cyc_d;
  logic [UW-1:0]               unit_q, unit_d;
  logic [4:0]                  bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0]       shift_q, shift_d;
  logic                        rep_q, rep_d;
  logic                        done_q, done_d;

  logic [UW-1:0] len;
  logic          unit_last;
  logic          state_last;
  logic          carrier;

  // Length in units of the state currently being played out.
  always_comb begin
    len = UW'(1);
    case (state_q)
      LEAD_MARK:  len = UW'(LEAD_MARK_UNITS);
      LEAD_SPACE: len = rep_q ? UW'(REP_SPACE_UNITS) : UW'(LEAD_SPACE_UNITS);
      BIT_MARK:   len = UW'(BIT_MARK_UNITS);
      BIT_SPACE:  len = shift_q[0] ? UW'(ONE_SPACE_UNITS) : UW'(ZERO_SPACE_UNITS);
      STOP_MARK:  len = UW'(STOP_MARK_UNITS);
      GUARD:      len = UW'(GUARD_UNITS);
      default:    len = UW'(1);
    endcase
  end

  assign unit_last  = (cyc_q == CW'(UNIT_CYC - 1));
  assign state_last = unit_last && (unit_q == len - 1'b1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    rep_d     = rep_q;
    cyc_d     = cyc_q;
    unit_d    = unit_q;
    done_d    = 1'b0;

    // Every state change coincides with state_last, so this restarts timing on entry.
    if (state_q == IDLE || state_last) begin
      cyc_d  = '0;
      unit_d = '0;
    end else if (unit_last) begin
      cyc_d  = '0;
      unit_d = unit_q + 1'b1;
    end else begin
      cyc_d = cyc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        bit_idx_d = '0;
        if (tx_start) begin
          shift_d = {~tx_data, tx_data, ~tx_addr, tx_addr};
          rep_d   = 1'b0;
          state_d = LEAD_MARK;
        end else if (tx_repeat) begin
          rep_d   = 1'b1;
          state_d = LEAD_MARK;
        end
      end
      LEAD_MARK: if (state_last) state_d = LEAD_SPACE;
      LEAD_SPACE: if (state_last) state_d = rep_q ? STOP_MARK : BIT_MARK;
      BIT_MARK: if (state_last) state_d = BIT_SPACE;
      BIT_SPACE: begin
        if (state_last) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          state_d   = (bit_idx_q == 5'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK: if (state_last) state_d = GUARD;
      GUARD: begin
        if (state_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      unit_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rep_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      unit_q    <= unit_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rep_q     <= rep_d;
      done_q    <= done_d;
    end
  end

  nec_ir_carrier #(
    .CAR_HALF (CAR_HALF)
  ) u_carrier (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (state_q != IDLE),
    .restart   (is_mark(state_d) && !is_mark(state_q)),
    .carrier   (carrier)
  );

  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;
  assign ir_env  = is_mark(state_q);
  assign ir_out  = ir_env & carrier;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Self-checking bench for nec_ir_tx: expected waveforms are built from the NEC
// frame rules as per-cycle envelope lists and compared every cycle.
module tb_nec_ir_tx;

  localparam int U     = 4;
  localparam int CAR   = 1;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start, tx_repeat;
  logic [7:0] tx_addr, tx_data;
  logic       tx_busy, tx_done, ir_env, ir_out;

  int n_vec = 0;
  int n_err = 0;

  bit exp_env[$];
  int exp_pos[$];
  int bit_start[32];

  typedef struct {
    logic       start;
    logic       rep;
    logic [7:0] addr;
    logic [7:0] data;
    int         inject;
    int         exp_cycles;
  } vec_t;

  vec_t tbl[8];

  nec_ir_tx #(
    .UNIT_CYC    (U),
    .CAR_HALF    (CAR),
    .GUARD_UNITS (GUARD)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .tx_start  (tx_start),
    .tx_repeat (tx_repeat),
    .tx_addr   (tx_addr),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .ir_env    (ir_env),
    .ir_out    (ir_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [3:0] exp);
    logic [3:0] act;
    act = {tx_busy, tx_done, ir_env, ir_out};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: busy/done/env/out got %b expected %b", name, k, act, exp);
    end
  endtask

  task automatic add_seg(input bit val, input int units);
    for (int i = 0; i < units * U; i++) begin
      exp_env.push_back(val);
      exp_pos.push_back(i);
    end
  endtask

  // Reference waveform straight from the NEC frame rules.
  task automatic build_model(input logic s, input logic r, input logic [7:0] a, input logic [7:0] d);
    logic [31:0] word;
    exp_env.delete();
    exp_pos.delete();
    word = {~d, d, ~a, a};
    add_seg(1'b1, 16);
    if (s) begin
      add_seg(1'b0, 8);
      for (int b = 0; b < 32; b++) begin
        bit_start[b] = exp_env.size();
        add_seg(1'b1, 1);
        add_seg(1'b0, word[b] ? 3 : 1);
      end
    end else begin
      add_seg(1'b0, 4);
    end
    add_seg(1'b1, 1);
    add_seg(1'b0, GUARD);
  endtask

  function automatic logic [3:0] exp_at(input int k);
    bit e, o;
    if (k >= exp_env.size()) return 4'b0000;
    e = exp_env[k];
    o = e && (((exp_pos[k] / CAR) % 2) == 0);
    return {1'b1, 1'b0, e, o};
  endfunction

  task automatic idle_checks(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, i, 4'b0000);
      @(negedge clk);
    end
  endtask

  // Sends one request; rst_bit >= 0 aborts the frame with a reset at that bit.
  task automatic run_txn(input int id, input vec_t v, input int rst_bit);
    int ncyc;
    build_model(v.start, v.rep, v.addr, v.data);
    ncyc = (v.exp_cycles > 0) ? v.exp_cycles : exp_env.size();
    @(negedge clk);
    tx_start = v.start; tx_repeat = v.rep; tx_addr = v.addr; tx_data = v.data;
    @(negedge clk);
    tx_start = 1'b0; tx_repeat = 1'b0;
    tx_addr = 8'($urandom); tx_data = 8'($urandom);
    for (int k = 0; k < ncyc; k++) begin
      check("frame", k, exp_at(k));
      if (rst_bit >= 0 && k == bit_start[rst_bit]) begin
        rst_n = 1'b0;
        #1;
        check("reset_mid", k, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle_checks("post_reset", 3);
        $display("txn %0d: start addr=%h data=%h reset at bit %0d cycle %0d", id, v.addr, v.data, rst_bit, k);
        return;
      end
      tx_start = (k == v.inject);
      if (k == v.inject) tx_data = 8'($urandom);
      @(negedge clk);
    end
    tx_start = 1'b0;
    check("done", ncyc, 4'b0100);
    @(negedge clk);
    idle_checks("after_done", 4);
    $display("txn %0d: start=%0b rep=%0b addr=%h data=%h inject=%0d cycles=%0d", id, v.start, v.rep,
             v.addr, v.data, v.inject, ncyc);
  endtask

  initial begin
    vec_t rv;
    rst_n = 1'b0;
    tx_start = 1'b0; tx_repeat = 1'b0; tx_addr = 8'h00; tx_data = 8'h00;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h45, -1, 492};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, -1, 92};
    tbl[2] = '{1'b1, 1'b1, 8'($urandom), 8'($urandom), -1, -1};
    tbl[3] = '{1'b1, 1'b0, 8'($urandom), 8'($urandom), 100, -1};
    for (int i = 4; i < 8; i++) begin
      tbl[i].start      = 1'($urandom);
      tbl[i].rep        = ~tbl[i].start | 1'($urandom);
      tbl[i].addr       = 8'($urandom);
      tbl[i].data       = 8'($urandom);
      tbl[i].inject     = tbl[i].start ? int'($urandom_range(96, 300)) : -1;
      tbl[i].exp_cycles = -1;
    end

    repeat (2) @(negedge clk);
    check("reset_state", 0, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    idle_checks("idle", 3);

    for (int i = 0; i < 8; i++) run_txn(i, tbl[i], -1);

    rv = '{1'b1, 1'b0, 8'($urandom), 8'($urandom), -1, -1};
    run_txn(8, rv, 10);
    run_txn(9, rv, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
